// File: rtl/wifi_tx_ilv_pkg.sv
// +----------------------------------------------------------------------------+
// | wifi_tx_ilv_pkg : shared types, constants and frame-length helper for the |
// |                   WIFI TX interleaver sequencer                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package wifi_tx_ilv_pkg;

  localparam int unsigned NCBPS    = 96;
  localparam int unsigned NCBPS_S  = 48;
  localparam int unsigned SYM_W    = 10;
  localparam int unsigned MAX_SYM  = 682;
  localparam int unsigned WD_SLACK = 16;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned WD_W     = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } ilv_state_e;

  // SIGNAL symbol plus n_sym DATA symbols; MAX_SYM keeps this inside 16 bits.
  function automatic logic [CNT_W-1:0] frame_bits(input logic [SYM_W-1:0] n_sym);
    logic [CNT_W-1:0] data_bits;
    data_bits = CNT_W'(n_sym) * CNT_W'(NCBPS);
    return data_bits + CNT_W'(NCBPS_S);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wifi_tx_ilv_watchdog.sv
// +----------------------------------------------------------------------------+
// | wifi_tx_ilv_watchdog : loadable-limit cycle counter flagging a stuck drain |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module wifi_tx_ilv_watchdog
  import wifi_tx_ilv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [WD_W-1:0] limit_i,
  input  logic            clear_i,
  input  logic            en_i,
  output logic            expired_o
);

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] limit_q;
  logic            armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      limit_q <= '0;
      armed_q <= 1'b0;
    end else if (load_i) begin
      cnt_q   <= '0;
      limit_q <= limit_i;
      armed_q <= 1'b1;
    end else if (clear_i) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = armed_q && (cnt_q >= limit_q);

endmodule

`default_nettype wire

// File: rtl/wifi_tx_ilv_sequencer.sv
// +----------------------------------------------------------------------------+
// | wifi_tx_ilv_sequencer : frame controller loading, draining and flushing    |
// |                         the 96-bit WIFI TX interleaver                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module wifi_tx_ilv_sequencer
  import wifi_tx_ilv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [SYM_W-1:0] n_sym_i,
  output logic             busy_o,
  input  logic             in_valid_i,
  input  logic             in_bit_i,
  output logic             in_ready_o,
  output logic             ilv_enable_o,
  output logic             ilv_valid_in_o,
  output logic             ilv_data_in_o,
  input  logic             ilv_valid_out_i,
  input  logic             ilv_finished_i,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] out_cnt_o,
  output logic             frame_done_o,
  output logic             err_o
);

  ilv_state_e       state_q;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] in_cnt_q;
  logic [CNT_W-1:0] in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q;
  logic [CNT_W-1:0] out_cnt_d;
  logic             busy_q;
  logic             in_ready_q;
  logic             frame_done_q;
  logic             err_q;
  logic             fin_low_q;

  logic [CNT_W-1:0] total_d;
  logic [WD_W-1:0]  wd_limit;
  logic             start_bad;
  logic             start_ok;
  logic             accept;
  logic             count_out;
  logic             in_last;
  logic             out_last;
  logic             draining;
  logic             wd_expired;
  logic             wd_en;

  assign total_d   = frame_bits(n_sym_i);
  assign wd_limit  = {1'b0, total_d} + WD_W'(WD_SLACK);
  assign start_bad = (n_sym_i == '0) || (n_sym_i > SYM_W'(MAX_SYM));
  assign start_ok  = (state_q == IDLE) && start_i && !start_bad;
  assign draining  = (state_q == DRAIN) || (state_q == FLUSH);

  // Read-out beats are only counted while draining, and never past the frame length.
  assign accept    = (state_q == LOAD) && in_ready_q && in_valid_i;
  assign count_out = draining && ilv_valid_out_i && (out_cnt_q != total_q);
  assign in_cnt_d  = in_cnt_q + {{(CNT_W-1){1'b0}}, accept};
  assign out_cnt_d = out_cnt_q + {{(CNT_W-1){1'b0}}, count_out};
  assign in_last   = accept && (in_cnt_d == total_q);
  assign out_last  = (out_cnt_d == total_q);

  // A load bubble must drop enable too: enable=1 with valid_in=0 starts the drain.
  always_comb begin
    ilv_enable_o   = 1'b0;
    ilv_valid_in_o = 1'b0;
    ilv_data_in_o  = 1'b0;
    case (state_q)
      LOAD: begin
        ilv_enable_o   = in_valid_i;
        ilv_valid_in_o = in_valid_i;
        ilv_data_in_o  = in_bit_i;
      end
      DRAIN:   ilv_enable_o = out_ready_i && !wd_expired;
      FLUSH:   ilv_enable_o = !wd_expired;
      default: ilv_enable_o = 1'b0;
    endcase
  end

  assign wd_en = draining && ilv_enable_o;

  wifi_tx_ilv_watchdog u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (start_ok),
    .limit_i   (wd_limit),
    .clear_i   (state_q == IDLE),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      total_q      <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      fin_low_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (start_bad) begin
              err_q <= 1'b1;
            end else begin
              total_q    <= total_d;
              in_cnt_q   <= '0;
              out_cnt_q  <= '0;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
              state_q    <= LOAD;
            end
          end
        end
        LOAD: begin
          if (in_last) begin
            in_ready_q <= 1'b0;
            state_q    <= DRAIN;
          end
        end
        DRAIN: begin
          if (wd_expired) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (out_last) begin
            fin_low_q <= 1'b0;
            state_q   <= FLUSH;
          end
        end
        FLUSH: begin
          // finished must be seen low before its rising level counts as done.
          if (wd_expired) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!ilv_finished_i) begin
            fin_low_q <= 1'b1;
          end else if (fin_low_q) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign in_ready_o   = in_ready_q;
  assign out_cnt_o    = out_cnt_q;
  assign frame_done_o = frame_done_q;
  assign err_o        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_wifi_tx_ilv_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_wifi_tx_ilv_sequencer : randomized bench with a behavioural interleaver |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_wifi_tx_ilv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [9:0]  n_sym_i;
  logic        busy_o;
  logic        in_valid_i;
  logic        in_bit_i;
  logic        in_ready_o;
  logic        ilv_enable_o;
  logic        ilv_valid_in_o;
  logic        ilv_data_in_o;
  logic        ilv_valid_out_i;
  logic        ilv_finished_i;
  logic        out_ready_i;
  logic [15:0] out_cnt_o;
  logic        frame_done_o;
  logic        err_o;

  always #5 clk = ~clk;

  wifi_tx_ilv_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .n_sym_i         (n_sym_i),
    .busy_o          (busy_o),
    .in_valid_i      (in_valid_i),
    .in_bit_i        (in_bit_i),
    .in_ready_o      (in_ready_o),
    .ilv_enable_o    (ilv_enable_o),
    .ilv_valid_in_o  (ilv_valid_in_o),
    .ilv_data_in_o   (ilv_data_in_o),
    .ilv_valid_out_i (ilv_valid_out_i),
    .ilv_finished_i  (ilv_finished_i),
    .out_ready_i     (out_ready_i),
    .out_cnt_o       (out_cnt_o),
    .frame_done_o    (frame_done_o),
    .err_o           (err_o)
  );

  int total_chk = 0;
  int bad_chk   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_chk++;
    if (got !== exp) begin
      bad_chk++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural interleaver: stores every written bit, then emits one bit per
  // enabled read cycle through a 4-deep output pipe; finished dips low while
  // reading and rises two cycles after the pipe empties (unless held low).
  logic       model_clr;
  logic       hold_fin;
  logic       stray_vout;
  logic [3:0] m_pipe;
  int         m_loaded;
  int         m_issued;
  int         m_fin_cnt;
  logic       m_fin;
  logic       m_started;
  logic       m_iss;

  assign m_iss           = ilv_enable_o && !ilv_valid_in_o && (m_issued < m_loaded);
  assign ilv_valid_out_i = m_pipe[3] | stray_vout;
  assign ilv_finished_i  = m_fin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pipe <= '0; m_loaded <= 0; m_issued <= 0; m_fin_cnt <= 0; m_fin <= 1'b1; m_started <= 1'b0;
    end else if (model_clr) begin
      m_pipe <= '0; m_loaded <= 0; m_issued <= 0; m_fin_cnt <= 0; m_fin <= 1'b1; m_started <= 1'b0;
    end else begin
      if (ilv_enable_o && ilv_valid_in_o) m_loaded <= m_loaded + 1;
      if (m_iss) begin
        m_issued  <= m_issued + 1;
        m_started <= 1'b1;
        m_fin     <= 1'b0;
      end
      m_pipe <= {m_pipe[2:0], m_iss};
      if (m_started && !m_iss && (m_issued == m_loaded) && (m_pipe == 4'd0) && !hold_fin) begin
        if (m_fin_cnt == 1) m_fin <= 1'b1;
        m_fin_cnt <= m_fin_cnt + 1;
      end
    end
  end

  // Per-cycle monitor: expected interface behaviour from the frame rules.
  logic frame_clr;
  int   exp_total;
  int   seen;
  int   wd_cnt;
  int   done_cnt;
  int   err_cnt;
  int   stall_extra;
  logic prev_or;
  logic exp_en;

  initial begin
    seen = 0; wd_cnt = 0; done_cnt = 0; err_cnt = 0; stall_extra = 0; prev_or = 1'b1;
    forever begin
      @(negedge clk);
      if (frame_clr) begin
        seen = 0; wd_cnt = 0; done_cnt = 0; err_cnt = 0; stall_extra = 0;
      end
      if (frame_done_o || err_o) check_val("done_err_excl", frame_done_o & err_o, 0);
      if (frame_done_o) done_cnt++;
      if (err_o) err_cnt++;
      if (!busy_o) begin
        check_val("idle_en", ilv_enable_o, 0);
        check_val("idle_vin", ilv_valid_in_o, 0);
      end else if (in_ready_o) begin
        check_val("ld_en", ilv_enable_o, in_valid_i);
        check_val("ld_vin", ilv_valid_in_o, in_valid_i);
        check_val("ld_data", ilv_data_in_o, in_bit_i);
      end else begin
        if (wd_cnt >= exp_total + 16) exp_en = 1'b0;
        else if (seen < exp_total)    exp_en = out_ready_i;
        else                          exp_en = 1'b1;
        check_val("dr_en", ilv_enable_o, exp_en);
        check_val("dr_vin", ilv_valid_in_o, 0);
        check_val("dr_cnt", out_cnt_o, seen);
        if (ilv_enable_o) wd_cnt++;
        if (ilv_valid_out_i) begin
          seen++;
          if (!out_ready_i && !prev_or) stall_extra++;
        end
      end
      prev_or = out_ready_i;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_busy"}, busy_o, 0);
    check_val({tag, "_rdy"}, in_ready_o, 0);
    check_val({tag, "_en"}, ilv_enable_o, 0);
    check_val({tag, "_vin"}, ilv_valid_in_o, 0);
    check_val({tag, "_din"}, ilv_data_in_o, 0);
    check_val({tag, "_cnt"}, out_cnt_o, 0);
    check_val({tag, "_done"}, frame_done_o, 0);
    check_val({tag, "_err"}, err_o, 0);
  endtask

  task automatic begin_frame(input int n);
    n_sym_i   = 10'(n);
    start_i   = 1'b1;
    model_clr = 1'b1;
    frame_clr = 1'b1;
    exp_total = 48 + 96 * n;
    tick();
    start_i   = 1'b0;
    model_clr = 1'b0;
    frame_clr = 1'b0;
  endtask

  // mode 0 gap-free, 1 toggling, 2 random bubbles; stop_at<0 feeds the whole frame
  task automatic feed(input int mode, input int stop_at, input bit inj_start, output int sent);
    int  guard;
    logic v;
    sent  = 0;
    guard = 0;
    while (sent < exp_total && sent != stop_at && guard < 20000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = ($urandom % 3 != 0);
      endcase
      in_valid_i = v;
      in_bit_i   = 1'($urandom % 2);
      if (inj_start && sent == 10) begin
        start_i = 1'b1;
        n_sym_i = 10'd5;
      end else begin
        start_i = 1'b0;
      end
      if (v && in_ready_o) sent++;
      tick();
      guard++;
    end
    in_valid_i = 1'b0;
    start_i    = 1'b0;
  endtask

  // stall 0 none, 1 one 20-cycle stall mid-drain, 2 random stalls
  task automatic wait_end(input int stall);
    int guard;
    int low;
    guard = 0;
    low   = 0;
    while (!frame_done_o && !err_o && guard < 3000) begin
      case (stall)
        0: out_ready_i = 1'b1;
        1: begin
          if (seen >= 100 && low < 20) begin
            out_ready_i = 1'b0;
            low++;
          end else begin
            out_ready_i = 1'b1;
          end
        end
        default: out_ready_i = ($urandom % 4 != 0);
      endcase
      tick();
      guard++;
    end
    out_ready_i = 1'b1;
    check_val("end_timeout", guard < 3000, 1);
  endtask

  task automatic run_frame(input int n, input int mode, input int stall, input bit hold, input bit inj);
    int sent;
    hold_fin = hold;
    begin_frame(n);
    check_val("start_busy", busy_o, 1);
    feed(mode, -1, inj, sent);
    check_val("loaded", sent, exp_total);
    check_val("rdy_off", in_ready_o, 0);
    wait_end(stall);
    check_val("end_done", frame_done_o, !hold);
    check_val("end_err", err_o, hold);
    check_val("end_busy", busy_o, 0);
    check_val("end_outcnt", out_cnt_o, exp_total);
    tick();
    check_val("pulse_done", frame_done_o, 0);
    check_val("pulse_err", err_o, 0);
    check_val("n_done", done_cnt, !hold);
    check_val("n_err", err_cnt, hold);
    if (hold) check_val("wd_len", wd_cnt, exp_total + 16);
    if (stall == 1) check_val("stall_extra", stall_extra <= 3, 1);
    hold_fin = 1'b0;
  endtask

  task automatic bad_start(input int n);
    begin_frame(n);
    check_val("bad_err", err_o, 1);
    check_val("bad_busy", busy_o, 0);
    check_val("bad_rdy", in_ready_o, 0);
    tick();
    check_val("bad_err_pulse", err_o, 0);
    check_val("bad_busy2", busy_o, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int sent;
    rst_n       = 1'b0;
    start_i     = 1'b0;
    n_sym_i     = '0;
    in_valid_i  = 1'b0;
    in_bit_i    = 1'b0;
    out_ready_i = 1'b1;
    model_clr   = 1'b0;
    frame_clr   = 1'b0;
    hold_fin    = 1'b0;
    stray_vout  = 1'b0;
    exp_total   = 0;
    repeat (3) tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    run_frame(1, 0, 0, 1'b0, 1'b0);

    stray_vout = 1'b1;
    repeat (3) tick();
    stray_vout = 1'b0;
    tick();
    check_val("stray_ignored", out_cnt_o, 144);

    run_frame(2, 1, 0, 1'b0, 1'b1);
    run_frame(3, 0, 1, 1'b0, 1'b0);

    bad_start(0);
    bad_start(683);
    bad_start(683 + int'($urandom % 341));

    run_frame(1, 0, 0, 1'b1, 1'b0);

    hold_fin = 1'b0;
    begin_frame(1);
    feed(0, 60, 1'b0, sent);
    check_val("pre_rst_sent", sent, 60);
    in_valid_i = 1'b1;
    rst_n      = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    in_valid_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_frame(1, 0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      run_frame(1 + int'($urandom % 4), 2, 2, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
    $finish;
  end

endmodule

`default_nettype wire
